mem_bist_master: RTL



---
 rtl/mem_bist_master.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bist_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_master
// Description : Initiator-side BIST engine for a single-port register-file
//               memory (synchronous write, registered read data). Runs a
//               two-phase write / read-back march. Phase 0 writes
//               SEED ^ addr to every word and reads it back. Phase 1 does
//               the same with the inverted pattern. It reports pass/fail,
//               the first failing location and a saturating error count.
// Ports       : clk, reset          clock, synchronous active-high reset
//               start_i             one-cycle request, honoured only in IDLE
//               mem_rd_en_o         read strobe to memory
//               mem_wr_en_o         write strobe to memory
//               mem_address_o       memory address
//               mem_w_data_o        memory write data
//               mem_r_data_i        memory registered read data
//               busy_o              test in progress
//               done_o              one-cycle completion pulse
//               pass_o              last run had zero mismatches
//               fail_valid_o        at least one mismatch recorded
//               fail_addr_o         address of first mismatch
//               fail_data_o         observed data at first mismatch
//               fail_phase_o        phase of first mismatch
//               err_count_o         saturating mismatch count
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_master #(
    parameter int                ADDR_W = 2,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = 8'hA5,
    parameter int                ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_w_data_o,
    input  logic [DATA_W-1:0] mem_r_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_valid_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_data_o,
    output logic              fail_phase_o,
    output logic [ERR_W-1:0]  err_count_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Phase-dependent test pattern: SEED ^ addr, inverted in phase 1.
    function automatic logic [DATA_W-1:0] pat(input logic ph, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = SEED ^ DATA_W'(a);
        return ph ? ~v : v;
    endfunction

    logic [1:0]        state_q,  state_d;
    logic              phase_q,  phase_d;
    logic              rd_en_q,  rd_en_d;
    logic              wr_en_q,  wr_en_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              pass_q,   pass_d;
    logic              fv_q,     fv_d;
    logic [ADDR_W-1:0] faddr_q,  faddr_d;
    logic [DATA_W-1:0] fdata_q,  fdata_d;
    logic              fphase_q, fphase_d;
    logic [ERR_W-1:0]  err_q,    err_d;

    // Compare pipeline. Stage 0 is loaded together with the read strobe.
    // Stage 1 lines up with the cycle in which the memory presents the
    // registered data, so the compare happens two edges after the strobe.
    logic              p0_valid_q, p0_valid_d;
    logic [ADDR_W-1:0] p0_addr_q,  p0_addr_d;
    logic [DATA_W-1:0] p0_exp_q,   p0_exp_d;
    logic              p1_valid_q;
    logic [ADDR_W-1:0] p1_addr_q;
    logic [DATA_W-1:0] p1_exp_q;

    logic w_mismatch;
    logic w_addr_last;

    assign w_mismatch  = p1_valid_q && (mem_r_data_i != p1_exp_q);
    assign w_addr_last = &addr_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rd_en_d    = rd_en_q;
        wr_en_d    = wr_en_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fv_d       = fv_q;
        faddr_d    = faddr_q;
        fdata_d    = fdata_q;
        fphase_d   = fphase_q;
        err_d      = err_q;
        p0_valid_d = 1'b0;
        p0_addr_d  = p0_addr_q;
        p0_exp_d   = p0_exp_q;

        // Compares only happen mid-run, so phase_q is still the phase the
        // read was issued in (the phase flips on the last compare's edge).
        if (w_mismatch) begin
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + 1'b1;
            end
            if (!fv_q) begin
                fv_d     = 1'b1;
                faddr_d  = p1_addr_q;
                fdata_d  = mem_r_data_i;
                fphase_d = phase_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                if (start_i) begin
                    state_d  = ST_WRITE;
                    phase_d  = 1'b0;
                    busy_d   = 1'b1;
                    wr_en_d  = 1'b1;
                    wdata_d  = pat(1'b0, '0);
                    pass_d   = 1'b0;
                    fv_d     = 1'b0;
                    faddr_d  = '0;
                    fdata_d  = '0;
                    fphase_d = 1'b0;
                    err_d    = '0;
                end
            end
            ST_WRITE: begin
                if (w_addr_last) begin
                    state_d    = ST_READ;
                    wr_en_d    = 1'b0;
                    rd_en_d    = 1'b1;
                    addr_d     = '0;
                    wdata_d    = '0;
                    p0_valid_d = 1'b1;
                    p0_addr_d  = '0;
                    p0_exp_d   = pat(phase_q, '0);
                end else begin
                    addr_d  = addr_q + 1'b1;
                    wdata_d = pat(phase_q, addr_q + 1'b1);
                end
            end
            ST_READ: begin
                if (w_addr_last) begin
                    state_d = ST_DRAIN;
                    rd_en_d = 1'b0;
                    addr_d  = '0;
                end else begin
                    addr_d     = addr_q + 1'b1;
                    p0_valid_d = 1'b1;
                    p0_addr_d  = addr_q + 1'b1;
                    p0_exp_d   = pat(phase_q, addr_q + 1'b1);
                end
            end
            ST_DRAIN: begin
                // The final read's compare lands on this exit edge, so the
                // next phase's first write never races a pending read.
                if (!phase_q) begin
                    state_d = ST_WRITE;
                    phase_d = 1'b1;
                    wr_en_d = 1'b1;
                    addr_d  = '0;
                    wdata_d = pat(1'b1, '0);
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fv_q       <= 1'b0;
            faddr_q    <= '0;
            fdata_q    <= '0;
            fphase_q   <= 1'b0;
            err_q      <= '0;
            p0_valid_q <= 1'b0;
            p0_addr_q  <= '0;
            p0_exp_q   <= '0;
            p1_valid_q <= 1'b0;
            p1_addr_q  <= '0;
            p1_exp_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fv_q       <= fv_d;
            faddr_q    <= faddr_d;
            fdata_q    <= fdata_d;
            fphase_q   <= fphase_d;
            err_q      <= err_d;
            p0_valid_q <= p0_valid_d;
            p0_addr_q  <= p0_addr_d;
            p0_exp_q   <= p0_exp_d;
            p1_valid_q <= p0_valid_q;
            p1_addr_q  <= p0_addr_q;
            p1_exp_q   <= p0_exp_q;
        end
    end

    assign mem_rd_en_o   = rd_en_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_address_o = addr_q;
    assign mem_w_data_o  = wdata_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign fail_valid_o  = fv_q;
    assign fail_addr_o   = faddr_q;
    assign fail_data_o   = fdata_q;
    assign fail_phase_o  = fphase_q;
    assign err_count_o   = err_q;

endmodule
`default_nettype wire
